dma_peripheral: RTL and testbench
=================================

DMA_PERIPHERAL -- requirements
Module: dma_peripheral

Interface
REQ-001 Parameter: DEPTH, 8, FIFO depth in bytes; power of two, 2 to 64.
REQ-002 CLK  input  1  single clock; DMA controller bus signals are synchronous to it.
REQ-003 RESET_N  input  1  asynchronous, active-low reset.
REQ-004 DREQ  output  1  DMA request to the controller, active high.
REQ-005 DACK  input  1  DMA acknowledge from the controller, active high.
REQ-006 IOR_N  input  1  I/O read strobe; the peripheral supplies a byte (device-to-memory).
REQ-007 IOW_N  input  1  I/O write strobe; the peripheral accepts a byte (memory-to-device).
REQ-008 DB  inout  8  data bus; driven only per REQ-016, else high-Z.
REQ-009 EOP_N  input  1  end-of-process from the controller, active low.
REQ-010 enable  input  1  local channel enable; dir  input  1  0 = device-to-memory, 1 = memory-to-device.
REQ-011 push/push_data[7:0]  input  local FIFO write; pop  input 1 and pop_data[7:0]  output  local FIFO read (first-word fall-through).
REQ-012 full, empty, done, ovf  output  1 each  FIFO status; sticky terminal flag; sticky overflow/underflow error flag.

Function
REQ-013 States: IDLE, REQ, ACK, XFER, DONE; DREQ is 1 in REQ, ACK and XFER only.
REQ-014 IDLE->REQ when enable and (dir=0 and not empty, or dir=1 and not full).
REQ-015 REQ->ACK when DACK=1 is sampled; ACK->XFER when the active strobe (IOR_N if dir=0, IOW_N if dir=1) is sampled low with DACK=1.
REQ-016 DB is driven combinationally with the FIFO head while DACK=1, IOR_N=0, dir=0 and the state is ACK or XFER.
REQ-017 dir=0: one pop per strobe, on the first clock where IOR_N is sampled high after being low in XFER.
REQ-018 dir=1: DB is registered on every clock IOW_N is low in XFER; the last registered value is pushed on the IOW_N rising edge detected.
REQ-019 After the strobe rises: XFER->REQ if the REQ-014 condition still holds after that pop or push, else XFER->IDLE; DREQ stays high across back-to-back bytes.
REQ-020 If DACK falls in ACK or XFER before a strobe completes: no FIFO update, return to REQ.
REQ-021 EOP_N sampled low while DACK=1: the current byte completes normally, then go to DONE; done=1 and DREQ=0 in DONE.
REQ-022 DONE->IDLE only when enable=0; done clears on that transition.
REQ-023 enable=0 in REQ: return to IDLE next clock. enable=0 in ACK or XFER: the current byte finishes first.
REQ-024 Local push and DMA pop in the same clock, or DMA push and local pop in the same clock: both take effect and the count is unchanged.
REQ-025 A push when full or a pop when empty is ignored and sets ovf; FIFO pointers wrap modulo DEPTH.
REQ-026 dir is sampled only in IDLE; changes in other states are ignored until the next IDLE.

Reset
REQ-027 RESET_N low: immediate state IDLE, DREQ=0, DB high-Z, FIFO empty, done=0, ovf=0, pop_data=0, including mid-transfer.
REQ-028 After reset release, the first DREQ assertion is no earlier than the second rising CLK edge.

Configuration
REQ-029 Macro DMA_PERIPH_EOP_DRIVE_EN: when defined, adds the ports cnt_load input 1, cnt_val[15:0] input and EOP_DRV_N output 1 (open-drain style, 1 = released).
REQ-030 With the macro: a 16-bit count loads on cnt_load and decrements on each completed byte; EOP_DRV_N=0 while the strobe is low on the byte where count=1; that byte ends in DONE; count=0 disables the feature.
REQ-031 Without the macro: no count logic and no EOP_DRV_N port; termination comes only from EOP_N.

Verification
REQ-032 dir=0, push 0xA5 then 0x3C, enable=1 -> DREQ=1 within 1 clock; two DACK/IOR_N cycles -> DB shows 0xA5 then 0x3C; empty=1, DREQ=0, state IDLE.
REQ-033 dir=1, DEPTH=8, 8 DACK/IOW_N writes of 0x00..0x07 -> full=1 after the eighth, DREQ=0; pop returns 0x00..0x07 in order.
REQ-034 dir=0, 4 bytes queued, EOP_N low during the second IOR_N strobe -> 2 bytes popped, done=1, DREQ=0; enable=0 -> done=0.
REQ-035 RESET_N low while IOR_N=0 and DB is driven -> DB high-Z and DREQ=0 in the same cycle; FIFO empty after release.
REQ-036 dir=1, FIFO at 7 of 8, local pop and DMA push in the same clock -> count stays 7, ovf=0; extra local push while full -> ovf=1.
REQ-037 With DMA_PERIPH_EOP_DRIVE_EN, cnt_val=3 and dir=0 -> EOP_DRV_N low only during the third strobe; state DONE afterward.

Source files
------------

// File: rtl/dma_peripheral.sv
// dma_peripheral: byte FIFO between a local push/pop port and a DREQ/DACK/IOR_N/IOW_N DMA handshake.
// Latency: DREQ one clock after the request condition; FIFO updates on the clock the strobe rise is sampled.
// Backpressure: DREQ withheld while FIFO empty (dir=0) or full (dir=1); bad local push/pop dropped, ovf set.
// Optional: DMA_PERIPH_EOP_DRIVE_EN adds a terminal byte counter that drives EOP_DRV_N.
module dma_peripheral #(
    parameter int DEPTH = 8
) (
    input  logic       CLK,
    input  logic       RESET_N,
    output logic       DREQ,
    input  logic       DACK,
    input  logic       IOR_N,
    input  logic       IOW_N,
    inout  wire  [7:0] DB,
    input  logic       EOP_N,
    input  logic       enable,
    input  logic       dir,
    input  logic       push,
    input  logic [7:0] push_data,
    input  logic       pop,
    output logic [7:0] pop_data,
    output logic       full,
    output logic       empty,
    output logic       done,
`ifdef DMA_PERIPH_EOP_DRIVE_EN
    input  logic        cnt_load,
    input  logic [15:0] cnt_val,
    output logic        EOP_DRV_N,
`endif
    output logic       ovf
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

    typedef enum logic [2:0] {IDLE, REQ, ACK, XFER, DONE} state_t;
    state_t state, state_nxt;

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   cnt, cnt_nxt;
    logic          dir_q, rst_seen, eop_seen;
    logic [7:0]    wr_byte;
    logic          strobe_n, in_bus, xfer_done;
    logic          dma_push, dma_pop, do_push, do_pop, push_ok, pop_ok;
    logic [7:0]    wdat;
    logic          terminal;

    // Request condition for a direction and a FIFO occupancy
    function automatic logic want(input logic en, input logic d, input logic [AW:0] c);
        return en && (d ? (c != DEPTH_C) : (c != '0));
    endfunction

    assign strobe_n  = dir_q ? IOW_N : IOR_N;
    assign in_bus    = (state == ACK) || (state == XFER);
    assign xfer_done = (state == XFER) && strobe_n;
    assign dma_pop   = xfer_done && !dir_q;
    assign dma_push  = xfer_done && dir_q;

    // The DMA side owns its FIFO end during a transfer, so it wins any collision with the same local port.
    assign do_push = push | dma_push;
    assign do_pop  = pop | dma_pop;
    assign wdat    = dma_push ? wr_byte : push_data;
    assign pop_ok  = do_pop && !empty;
    assign push_ok = do_push && (!full || pop_ok);

    assign full     = (cnt == DEPTH_C);
    assign empty    = (cnt == '0);
    assign pop_data = empty ? 8'h00 : mem[rd_ptr];
    assign DREQ     = (state == REQ) || in_bus;
    assign done     = (state == DONE);
    assign DB       = (in_bus && DACK && !IOR_N && !dir_q) ? mem[rd_ptr] : 8'hzz;

`ifdef DMA_PERIPH_EOP_DRIVE_EN
    logic [15:0] bcnt;
    assign terminal  = (bcnt == 16'd1);
    assign EOP_DRV_N = !(terminal && in_bus && DACK && !strobe_n);

    // Remaining-byte counter; zero leaves termination to EOP_N alone
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N)                     bcnt <= '0;
        else if (cnt_load)                bcnt <= cnt_val;
        else if (xfer_done && bcnt != '0) bcnt <= bcnt - 16'd1;
    end
`else
    assign terminal = 1'b0;
`endif

    // Occupancy after this clock's accepted push/pop
    always_comb begin
        cnt_nxt = cnt;
        if (push_ok && !pop_ok)      cnt_nxt = cnt + 1'b1;
        else if (pop_ok && !push_ok) cnt_nxt = cnt - 1'b1;
    end

    // FIFO storage, written without reset
    always_ff @(posedge CLK) begin
        if (push_ok) mem[wr_ptr] <= wdat;
    end

    // FIFO pointers, occupancy and sticky error flag
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
            ovf    <= 1'b0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
            cnt <= cnt_nxt;
            if ((do_push && !push_ok) || (do_pop && !pop_ok)) ovf <= 1'b1;
        end
    end

    // Handshake state, direction latch, write byte capture and EOP memory
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state    <= IDLE;
            dir_q    <= 1'b0;
            rst_seen <= 1'b0;
            eop_seen <= 1'b0;
            wr_byte  <= 8'h00;
        end else begin
            state    <= state_nxt;
            rst_seen <= 1'b1;
            if (state == IDLE) dir_q <= dir;
            if (in_bus && dir_q && DACK && !IOW_N) wr_byte <= DB;
            if (state == IDLE || state == DONE) eop_seen <= 1'b0;
            else if (DACK && !EOP_N)            eop_seen <= 1'b1;
        end
    end

    // Next-state: request, acknowledge, strobe, completion or abort
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (rst_seen && want(enable, dir, cnt)) state_nxt = REQ;
            REQ: begin
                if (!enable)   state_nxt = IDLE;
                else if (DACK) state_nxt = ACK;
            end
            ACK: begin
                if (!DACK)          state_nxt = REQ;
                else if (!strobe_n) state_nxt = XFER;
            end
            XFER: begin
                if (strobe_n) begin
                    if (eop_seen || (DACK && !EOP_N) || terminal) state_nxt = DONE;
                    else if (want(enable, dir_q, cnt_nxt))          state_nxt = REQ;
                    else                                            state_nxt = IDLE;
                end else if (!DACK) begin
                    state_nxt = REQ;
                end
            end
            DONE: if (!enable) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end
endmodule

// File: tb/tb_dma_peripheral.sv
// tb_dma_peripheral: directed plus randomized DMA/local traffic against a queue-based FIFO model.
// Latency: inputs driven 2ns after CLK rise, outputs compared there or 1ns after a combinational change.
// Backpressure: DMA controller behaviour modelled by tasks that only start a byte when DREQ is expected.
module tb_dma_peripheral;
    localparam int DEPTH = 8;

    logic       CLK = 1'b0;
    logic       RESET_N, DREQ, DACK, IOR_N, IOW_N, EOP_N, enable, dir, push, pop;
    logic [7:0] push_data, pop_data;
    logic       full, empty, done, ovf;
    logic       tb_oe;
    logic [7:0] tb_dat;
    wire  [7:0] DB;
`ifdef DMA_PERIPH_EOP_DRIVE_EN
    logic        cnt_load, EOP_DRV_N;
    logic [15:0] cnt_val;
`endif

    int n_assert = 0;
    int n_fail   = 0;
    logic [7:0] q[$];
    bit         ovf_m;

    assign DB = tb_oe ? tb_dat : 8'hzz;
    for (genvar i = 0; i < 8; i++) begin : g_pu
        pullup pu (DB[i]);
    end

    dma_peripheral #(.DEPTH(DEPTH)) dut (
        .CLK(CLK), .RESET_N(RESET_N), .DREQ(DREQ), .DACK(DACK), .IOR_N(IOR_N),
        .IOW_N(IOW_N), .DB(DB), .EOP_N(EOP_N), .enable(enable), .dir(dir),
        .push(push), .push_data(push_data), .pop(pop), .pop_data(pop_data),
        .full(full), .empty(empty), .done(done),
`ifdef DMA_PERIPH_EOP_DRIVE_EN
        .cnt_load(cnt_load), .cnt_val(cnt_val), .EOP_DRV_N(EOP_DRV_N),
`endif
        .ovf(ovf)
    );

    always #5 CLK = ~CLK;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, observed time=%0t required=<200000", $time);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #2;
    endtask

    task automatic lpush(input logic [7:0] d);
        push = 1'b1; push_data = d;
        tick();
        push = 1'b0;
        if (q.size() < DEPTH) q.push_back(d);
        else ovf_m = 1'b1;
    endtask

    task automatic lpop_chk(input string tag);
        chk(tag, pop_data, q[0]);
        pop = 1'b1;
        tick();
        pop = 1'b0;
        void'(q.pop_front());
    endtask

    // Controller reads one byte: DACK, IOR_N low for two clocks, rise
    task automatic dma_rd(input bit eop, output logic [7:0] got, output logic eopdrv);
        DACK = 1'b1;
        tick();
        IOR_N = 1'b0; EOP_N = !eop;
        #1 got = DB;
`ifdef DMA_PERIPH_EOP_DRIVE_EN
        eopdrv = EOP_DRV_N;
`else
        eopdrv = 1'b1;
`endif
        #1;
        tick();
        tick();
        IOR_N = 1'b1; EOP_N = 1'b1;
        tick();
        DACK = 1'b0;
    endtask

    // Controller writes one byte; lpop adds a local pop on the completing clock
    task automatic dma_wr(input logic [7:0] d, input bit lpop);
        DACK = 1'b1;
        tick();
        IOW_N = 1'b0; tb_oe = 1'b1; tb_dat = d;
        tick();
        tick();
        IOW_N = 1'b1; tb_oe = 1'b0; pop = lpop;
        tick();
        DACK = 1'b0; pop = 1'b0;
        if (lpop) void'(q.pop_front());
        q.push_back(d);
    endtask

    initial begin
        logic [7:0] got, d, exp;
        logic       drv;
        int         n;
        RESET_N = 1'b0; DACK = 1'b0; IOR_N = 1'b1; IOW_N = 1'b1; EOP_N = 1'b1;
        enable = 1'b0; dir = 1'b1; push = 1'b0; push_data = 8'h00; pop = 1'b0;
        tb_oe = 1'b0; tb_dat = 8'h00; ovf_m = 1'b0;
`ifdef DMA_PERIPH_EOP_DRIVE_EN
        cnt_load = 1'b0; cnt_val = 16'd0;
`endif
        tick(); tick();
        chk("rst_dreq", DREQ, 0);
        chk("rst_empty", empty, 1);
        chk("rst_full", full, 0);
        chk("rst_done", done, 0);
        chk("rst_ovf", ovf, 0);
        chk("rst_pop_data", pop_data, 8'h00);
        chk("rst_db_released", DB, 8'hFF);

        // Reset release with request condition already true
        enable = 1'b1; dir = 1'b1;
        RESET_N = 1'b1;
        tick();
        chk("dreq_not_first_edge", DREQ, 0);
        tick();
        chk("dreq_second_edge", DREQ, 1);
        enable = 1'b0;
        tick();
        chk("req_disable_idle", DREQ, 0);

        // Device-to-memory: two fixed bytes, then randomized bursts
        dir = 1'b0;
        lpush(8'hA5); lpush(8'h3C);
        enable = 1'b1;
        tick();
        chk("rd_dreq_1clk", DREQ, 1);
        dma_rd(1'b0, got, drv);
        chk("rd_db_a5", got, 8'hA5); void'(q.pop_front());
        chk("rd_dreq_b2b", DREQ, 1);
        dma_rd(1'b0, got, drv);
        chk("rd_db_3c", got, 8'h3C); void'(q.pop_front());
        chk("rd_empty", empty, 1);
        chk("rd_dreq_idle", DREQ, 0);
        enable = 1'b0;
        tick();
        for (int r = 0; r < 3; r++) begin
            n = $urandom_range(1, DEPTH);
            for (int i = 0; i < n; i++) lpush(8'($urandom_range(0, 255)));
            chk("rnd_full", full, (q.size() == DEPTH) ? 1 : 0);
            enable = 1'b1;
            tick();
            for (int i = 0; i < n; i++) begin
                chk("rnd_dreq", DREQ, 1);
                exp = q.pop_front();
                dma_rd(1'b0, got, drv);
                chk("rnd_db", got, exp);
            end
            chk("rnd_empty", empty, 1);
            chk("rnd_dreq_end", DREQ, 0);
            enable = 1'b0;
            tick();
        end

        // Memory-to-device: fill to full via DMA, drain locally
        dir = 1'b1; enable = 1'b1;
        tick();
        for (int i = 0; i < DEPTH; i++) begin
            chk("wr_dreq", DREQ, 1);
            dma_wr(8'(i), 1'b0);
        end
        chk("wr_full", full, 1);
        chk("wr_dreq_full", DREQ, 0);
        enable = 1'b0;
        tick();
        for (int i = 0; i < DEPTH; i++) lpop_chk("wr_drain");
        chk("wr_drain_empty", empty, 1);

        // Concurrent DMA push and local pop at 7 of 8, then overflow
        for (int i = 0; i < DEPTH - 1; i++) lpush(8'($urandom_range(0, 255)));
        enable = 1'b1;
        tick();
        chk("cc_dreq", DREQ, 1);
        d = 8'($urandom_range(0, 255));
        chk("cc_head", pop_data, q[0]);
        dma_wr(d, 1'b1);
        chk("cc_not_full", full, 0);
        chk("cc_ovf", ovf, 0);
        chk("cc_dreq_hold", DREQ, 1);
        enable = 1'b0;
        tick();
        lpush(8'($urandom_range(0, 255)));
        chk("cc_full", full, 1);
        lpush(8'h77);
        chk("ovf_set", ovf, ovf_m);
        for (int i = 0; i < DEPTH; i++) lpop_chk("cc_drain");
        chk("cc_drain_empty", empty, 1);

        // EOP during the second strobe of four queued bytes
        dir = 1'b0;
        for (int i = 0; i < 4; i++) lpush(8'($urandom_range(0, 255)));
        enable = 1'b1;
        tick();
        exp = q.pop_front();
        dma_rd(1'b0, got, drv);
        chk("eop_b1", got, exp);
        exp = q.pop_front();
        dma_rd(1'b1, got, drv);
        chk("eop_b2", got, exp);
        chk("eop_done", done, 1);
        chk("eop_dreq", DREQ, 0);
        tick();
        chk("eop_done_hold", done, 1);
        enable = 1'b0;
        tick();
        chk("eop_done_clr", done, 0);
        lpop_chk("eop_left1");
        lpop_chk("eop_left2");
        chk("eop_left_empty", empty, 1);

        // DACK withdrawn mid-strobe: no pop, request re-raised
        d = 8'($urandom_range(0, 254));
        lpush(d);
        enable = 1'b1;
        tick();
        DACK = 1'b1; tick();
        IOR_N = 1'b0; tick();
        DACK = 1'b0; tick();
        chk("abort_dreq", DREQ, 1);
        chk("abort_no_pop", pop_data, d);
        IOR_N = 1'b1; tick();
        dma_rd(1'b0, got, drv);
        chk("abort_retry", got, d); void'(q.pop_front());
        chk("abort_empty", empty, 1);
        enable = 1'b0;
        tick();

        // Reset while the DUT is driving DB
        lpush(8'h12); lpush(8'h34);
        enable = 1'b1;
        tick();
        DACK = 1'b1; tick();
        IOR_N = 1'b0;
        #1 chk("mid_db_driven", DB, 8'h12);
        RESET_N = 1'b0;
        #1;
        chk("mid_rst_db", DB, 8'hFF);
        chk("mid_rst_dreq", DREQ, 0);
        chk("mid_rst_empty", empty, 1);
        chk("mid_rst_ovf", ovf, 0);
        q.delete(); ovf_m = 1'b0;
        DACK = 1'b0; IOR_N = 1'b1; enable = 1'b0;
        tick();
        RESET_N = 1'b1;
        tick();
        chk("post_rst_empty", empty, 1);
        chk("post_rst_pop_data", pop_data, 8'h00);

`ifdef DMA_PERIPH_EOP_DRIVE_EN
        // Terminal count of three bytes drives EOP_DRV_N on the third strobe
        dir = 1'b0;
        cnt_load = 1'b1; cnt_val = 16'd3;
        tick();
        cnt_load = 1'b0;
        for (int i = 0; i < 4; i++) lpush(8'($urandom_range(0, 255)));
        enable = 1'b1;
        tick();
        for (int i = 0; i < 3; i++) begin
            exp = q.pop_front();
            dma_rd(1'b0, got, drv);
            chk("tc_db", got, exp);
            chk("tc_eop_drv", drv, (i == 2) ? 0 : 1);
        end
        chk("tc_done", done, 1);
        chk("tc_dreq", DREQ, 0);
        enable = 1'b0;
        tick();
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
